// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Two-requester arbiter feeding a single registered output stage. Requesters A
// and B present valid/data and receive a combinational ready. The arbiter grants
// one requester at a time, for at most MAX_BURST consecutive transfers while the
// other requester waits. After a burst, or when the granted side runs dry, the
// grant moves to the other side. Grants alternate when both sides ask at once
// from IDLE. The current grant is also driven on sel_a to steer a shared 2:1
// scale mux.
//
// Parameters
//   WIDTH      data width of both requesters and of the output word
//   MAX_BURST  maximum consecutive transfers per grant under contention (1-255)
//
// Ports
//   clk        rising-edge clock
//   rst_       asynchronous active-low reset
//   a_valid    requester A offers a_data
//   a_data     requester A data word
//   a_ready    A is accepted this cycle when a_valid is also high
//   b_valid    requester B offers b_data
//   b_data     requester B data word
//   b_ready    B is accepted this cycle when b_valid is also high
//   out_valid  out_data holds a valid word
//   out_data   last accepted (granted) word
//   out_ready  sink accepts out_data this cycle
//   sel_a      registered current grant (1 = A, 0 = B), held while IDLE
// -----------------------------------------------------------------------------
module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel_a
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_e;

    // Count value of the final transfer of a burst.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    // last_grant encoding: 1 = A was granted last, 0 = B.
    localparam logic LG_A = 1'b1;
    localparam logic LG_B = 1'b0;

    state_e             state_q,      state_d;
    logic               last_grant_q, last_grant_d;
    logic [7:0]         burst_cnt_q,  burst_cnt_d;
    logic               out_valid_q,  out_valid_d;
    logic [WIDTH-1:0]   out_data_q,   out_data_d;
    logic               sel_a_q,      sel_a_d;

    logic               slot_free_s;
    logic               a_ready_s;
    logic               b_ready_s;
    logic               accept_a_s;
    logic               accept_b_s;

    // Maps a "the other side wants it" flag to the state the grant moves to
    // when the current owner gives up: the other grant, or a fallback state.
    function automatic state_e pick_next(input logic other_valid,
                                         input state_e other_state,
                                         input state_e fallback);
        state_e res;
        if (other_valid) begin
            res = other_state;
        end else begin
            res = fallback;
        end
        return res;
    endfunction

    // Handshake: the output register can take a word when empty or draining.
    always_comb begin
        slot_free_s = (!out_valid_q) || out_ready;
        a_ready_s   = (state_q == GNT_A) && slot_free_s;
        b_ready_s   = (state_q == GNT_B) && slot_free_s;
        accept_a_s  = a_ready_s && a_valid;
        accept_b_s  = b_ready_s && b_valid;
    end

    // Next-state and burst counter.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = 8'd0;
                if (a_valid && b_valid) begin
                    // Alternate against whoever was served last.
                    if (last_grant_q == LG_A) begin
                        state_d = GNT_B;
                    end else begin
                        state_d = GNT_A;
                    end
                end else if (a_valid) begin
                    state_d = GNT_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_A: begin
                if (accept_a_s) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        // Burst exhausted: yield only if B is actually waiting.
                        burst_cnt_d = 8'd0;
                        state_d     = pick_next(b_valid, GNT_B, GNT_A);
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        state_d     = GNT_A;
                    end
                end else if (!a_valid) begin
                    burst_cnt_d = 8'd0;
                    state_d     = pick_next(b_valid, GNT_B, IDLE);
                end else begin
                    // A is waiting on backpressure: keep the grant and count.
                    burst_cnt_d = burst_cnt_q;
                    state_d     = GNT_A;
                end
            end
            GNT_B: begin
                if (accept_b_s) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        burst_cnt_d = 8'd0;
                        state_d     = pick_next(a_valid, GNT_A, GNT_B);
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        state_d     = GNT_B;
                    end
                end else if (!b_valid) begin
                    burst_cnt_d = 8'd0;
                    state_d     = pick_next(a_valid, GNT_A, IDLE);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                    state_d     = GNT_B;
                end
            end
            default: begin
                // Unused encoding: recover to a clean idle.
                burst_cnt_d = 8'd0;
                state_d     = IDLE;
            end
        endcase
    end

    // Grant bookkeeping: last_grant and sel_a follow the state being entered.
    always_comb begin
        last_grant_d = last_grant_q;
        sel_a_d      = sel_a_q;
        case (state_d)
            GNT_A: begin
                last_grant_d = LG_A;
                sel_a_d      = 1'b1;
            end
            GNT_B: begin
                last_grant_d = LG_B;
                sel_a_d      = 1'b0;
            end
            default: begin
                last_grant_d = last_grant_q;
                sel_a_d      = sel_a_q;
            end
        endcase
    end

    // Output register: load on accept, otherwise drain when the sink takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_a_s) begin
            out_valid_d = 1'b1;
            out_data_d  = a_data;
        end else if (accept_b_s) begin
            out_valid_d = 1'b1;
            out_data_d  = b_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            last_grant_q <= LG_B;
            burst_cnt_q  <= 8'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            sel_a_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            sel_a_q      <= sel_a_d;
        end
    end

    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel_a     = sel_a_q;

endmodule
